// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } store_lanes_t;

    // Byte enables plus write data replicated so every enabled lane sees its byte.
    function automatic store_lanes_t store_lanes(input size_e size, input logic [1:0] off,
                                                 input logic [31:0] wdata);
        store_lanes_t r;
        r.be   = '0;
        r.data = '0;
        case (size)
            SZ_BYTE: begin
                r.be   = 4'b0001 << off;
                r.data = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                r.be   = off[1] ? 4'b1100 : 4'b0011;
                r.data = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                r.be   = '1;
                r.data = wdata;
            end
            default: ;
        endcase
        return r;
    endfunction

    // Select byte/half from the fetched word and sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input size_e size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            SZ_WORD: r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with byte-enable write and registered read; no storage reset.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Write enabled lanes on stores; load reads update the held read word only.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: request accept, fixed-latency wait, held response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_e       state, state_nxt;
    logic [3:0]   cnt, cnt_nxt;
    logic         accept;
    logic         req_err;
    size_e        req_sz;
    store_lanes_t lanes;
    logic [31:0]  rd_word;

    logic         we_q;
    logic         err_q;
    logic         uns_q;
    size_e        size_q;
    logic [1:0]   off_q;

    assign req_sz = size_e'(req_size);
    assign lanes  = store_lanes(req_sz, req_addr[1:0], req_wdata);
    assign accept = req_valid && req_ready;

    // Misaligned, illegal-size or out-of-range access check.
    always_comb begin
        req_err = 1'b0;
        if (req_sz == SZ_ILL)                                req_err = 1'b1;
        if (req_sz == SZ_HALF && req_addr[0])                req_err = 1'b1;
        if (req_sz == SZ_WORD && req_addr[1:0] != 2'b00)     req_err = 1'b1;
        if (req_addr[31:2] >= 30'(DEPTH_WORDS))              req_err = 1'b1;
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .en   (accept && !req_err),
        .we   (req_we),
        .be   (lanes.be),
        .addr (req_addr[AW+1:2]),
        .wdata(lanes.data),
        .rdata(rd_word)
    );

    // State and latency counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Request attributes captured on the accept edge for response formatting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            uns_q  <= 1'b0;
            size_q <= SZ_BYTE;
            off_q  <= '0;
        end else if (accept) begin
            we_q   <= req_we;
            err_q  <= req_err;
            uns_q  <= req_unsigned;
            size_q <= req_sz;
            off_q  <= req_addr[1:0];
        end
    end

    // Next-state, handshake outputs and counter update.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response data from registered read word and captured attributes; held while in RESP.
    always_comb begin
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        if (state == RESP) begin
            rsp_err = err_q;
            if (!we_q && !err_q) begin
                rsp_rdata = load_extract(rd_word, off_q, size_q, uns_q);
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with hand-computed expectations.
module tb_dmem_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY    (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_err"},   32'(rsp_err), 32'd0);
    endtask

    // One full transaction with rsp_ready high; checks accept, latency and response.
    task automatic run(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_d, input logic exp_e);
        int n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        rsp_ready    = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_acc_wait"}, 32'(n), 32'd0);
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_addr     = 32'hFFFF_FFFF;
        req_wdata    = 32'h0BAD_0BAD;
        req_size     = 2'b11;
        req_unsigned = ~uns;
        @(negedge clk);
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"},   32'(n), 32'(LAT));
        check({tag, "_rdata"}, rsp_rdata, exp_d);
        check({tag, "_err"},   32'(rsp_err), 32'(exp_e));
        @(posedge clk);
    endtask

    initial begin
        int n;
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        rsp_ready    = 1'b0;

        // Reset held for three cycles, then released.
        repeat (3) begin
            @(negedge clk);
            check_idle("rst");
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_idle("post_rst");
        end

        // Basic word store/load.
        run("sw_0",     1'b1, 32'h0,  32'hCAFE_F00D, 2'b10, 1'b0, 32'h0,         1'b0);
        run("sw_10",    1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0,         1'b0);
        run("lw_10",    1'b0, 32'h10, 32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Byte store and sign/zero-extended loads.
        run("sb_13",    1'b1, 32'h13, 32'h1234_5680, 2'b00, 1'b0, 32'h0,         1'b0);
        run("lb_13",    1'b0, 32'h13, 32'h0,         2'b00, 1'b0, 32'hFFFF_FF80, 1'b0);
        run("lbu_13",   1'b0, 32'h13, 32'h0,         2'b00, 1'b1, 32'h0000_0080, 1'b0);
        run("lw_10b",   1'b0, 32'h10, 32'h0,         2'b10, 1'b0, 32'h80AD_BEEF, 1'b0);
        run("lh_12",    1'b0, 32'h12, 32'h0,         2'b01, 1'b0, 32'hFFFF_80AD, 1'b0);
        run("lhu_10",   1'b0, 32'h10, 32'h0,         2'b01, 1'b1, 32'h0000_BEEF, 1'b0);
        run("lb_11",    1'b0, 32'h11, 32'h0,         2'b00, 1'b0, 32'hFFFF_FFBE, 1'b0);
        run("lbu_10",   1'b0, 32'h10, 32'h0,         2'b00, 1'b1, 32'h0000_00EF, 1'b0);

        // Half and byte lane merging into a cleared word.
        run("sw_14",    1'b1, 32'h14, 32'h0,         2'b10, 1'b0, 32'h0,         1'b0);
        run("sh_16",    1'b1, 32'h16, 32'hFFFF_A5A5, 2'b01, 1'b0, 32'h0,         1'b0);
        run("sb_14",    1'b1, 32'h14, 32'hFFFF_FF3C, 2'b00, 1'b0, 32'h0,         1'b0);
        run("lw_14",    1'b0, 32'h14, 32'h0,         2'b10, 1'b0, 32'hA5A5_003C, 1'b0);

        // Error cases, none of which may touch the array.
        run("lh_11",    1'b0, 32'h11,   32'h0,         2'b01, 1'b0, 32'h0,         1'b1);
        run("sw_1000",  1'b1, 32'h1000, 32'h1111_1111, 2'b10, 1'b0, 32'h0,         1'b1);
        run("lw_0_a",   1'b0, 32'h0,    32'h0,         2'b10, 1'b0, 32'hCAFE_F00D, 1'b0);
        run("sz11",     1'b1, 32'h0,    32'h0,         2'b11, 1'b0, 32'h0,         1'b1);
        run("sw_2",     1'b1, 32'h2,    32'h2222_2222, 2'b10, 1'b0, 32'h0,         1'b1);
        run("sh_1",     1'b1, 32'h1,    32'h3333_3333, 2'b01, 1'b0, 32'h0,         1'b1);
        run("lw_0_b",   1'b0, 32'h0,    32'h0,         2'b10, 1'b0, 32'hCAFE_F00D, 1'b0);
        run("lw_1000",  1'b0, 32'h1000, 32'h0,         2'b10, 1'b0, 32'h0,         1'b1);

        // Last in-range word.
        run("sw_ffc",   1'b1, 32'hFFC, 32'h5A5A_5A5A, 2'b10, 1'b0, 32'h0,         1'b0);
        run("lw_ffc",   1'b0, 32'hFFC, 32'h0,         2'b10, 1'b0, 32'h5A5A_5A5A, 1'b0);

        // Backpressure: response held, request channel blocked until after handshake.
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 32'h10;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        rsp_ready    = 1'b0;
        check("bp_ready_pre", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_addr = 32'h0;
        @(negedge clk);
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_lat", 32'(n), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, 32'h80AD_BEEF);
            check("bp_err",   32'(rsp_err), 32'd0);
            check("bp_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("bp_hs_ready", 32'(req_ready), 32'd0);
        check("bp_hs_rdata", rsp_rdata, 32'h80AD_BEEF);
        @(posedge clk);
        @(negedge clk);
        check("bp_after_valid", 32'(rsp_valid), 32'd0);
        check("bp_after_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_next_lat",   32'(n), 32'(LAT));
        check("bp_next_rdata", rsp_rdata, 32'hCAFE_F00D);
        @(posedge clk);

        // Reset during WAIT of a store: response dropped, store kept.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1234_5678;
        req_size  = 2'b10;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rw_wait_valid", 32'(rsp_valid), 32'd0);
        check("rw_wait_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check_idle("rw_async");
        repeat (2) begin
            @(negedge clk);
            check_idle("rw_held");
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("rw_release");
        end
        run("lw_20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h1234_5678, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
